snake_collision_checker: RTL and testbench
==========================================

Name: snake_collision_checker

Overview:
- Consumer end of the flattened snake-location bus: takes the serialized X/Y coordinate vectors and the segment count, and unpacks segments one per clock.
- Reports per frame whether the head overlaps any body segment (self-collision) or lies outside the playfield (wall hit).
- Sits between the snake generator and the game-state logic; triggered once per screen-refresh tick by a start pulse.

Parameters:
- MAX_SEGS, 128, number of segment slots carried on the bus.
- X_W, 8, bits per X coordinate.
- Y_W, 9, bits per Y coordinate.
- FIELD_W, 240, first illegal X value; legal X is 0..FIELD_W-1.
- FIELD_H, 320, first illegal Y value; legal Y is 0..FIELD_H-1.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- start  in  1  one-cycle request to check the current frame; sampled only in IDLE.
- snakeLocX  in  MAX_SEGS*X_W  flattened X; segment i occupies bits [i*X_W +: X_W]; segment 0 is the head.
- snakeLocY  in  MAX_SEGS*Y_W  flattened Y; same packing with Y_W.
- size  in  8  number of valid segments.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- selfHit  out  1  head equals a body segment; held until next start.
- wallHit  out  1  head outside the field; held until next start.
- hitIndex  out  7  index of the first body segment matching the head; 0 if none.
- gameOver  out  1  sticky loss flag (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, selfHit, wallHit, gameOver = 0; hitIndex = 0; internal idx = 0. Reset mid-scan aborts immediately with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge E0:
  - latch headX/headY from segment 0;
  - latch limit = (size==0) ? 1 : min(size, MAX_SEGS);
  - wallHit <= (headX >= FIELD_W) || (headY >= FIELD_H), unsigned compare, so underflow wrap counts as a wall hit;
  - clear selfHit and hitIndex; idx <= 1; busy <= 1; go to SCAN.
- SCAN, each edge:
  - if idx >= limit: go to DONE;
  - else if segment[idx] == {headX, headY}: selfHit <= 1, hitIndex <= idx, go to DONE (first match wins, early exit);
  - else idx <= idx+1.
- DONE: done=1 for exactly one cycle and busy=0 in that cycle; return to IDLE on the next edge.
- Latency: done is high in the cycle after edge E_n, where n = j for a hit at index j, else n = limit. Size 0 or 1 gives done in the cycle after E1.
- Inputs other than start are sampled live during SCAN. The producer holds the bus stable from start until done; segments at or beyond limit are never read.
- start is ignored while in SCAN or DONE (no queuing). start that is high continuously re-triggers once per return to IDLE.
- A wall check and a self check can both flag in the same frame.
- Segment select is a registered-index mux over the flat bus. Comparisons use full X_W/Y_W widths with no truncation.

Optional Feature:
- Macro SNAKE_COLLIDE_STICKY_GAMEOVER_EN.
- Defined: gameOver is set in the DONE state if selfHit or wallHit is set; it stays 1, ignoring start, until reset=0.
- Undefined: gameOver is tied to 0 and no sticky register is built.

Decomposition:
- Package snake_pkg holds:
  - MAX_SEGS, X_W, Y_W, FIELD_W, FIELD_H defaults;
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - segment-index width constant (7).
- One sub-module, snake_seg_select: combinational extraction of segment idx X/Y from the flat vectors. It is reusable by the renderer.

Test Plan:
- Reset, then start with size=1, head (100,160) -> done in the cycle after E1; selfHit=0, wallHit=0, hitIndex=0.
- size=5, segs (100,160),(90,160),(80,160),(80,170),(90,170), no overlap -> done after E5; selfHit=0.
- size=6, segment 4 = head (100,160) -> done after E4, selfHit=1, hitIndex=4; segment 5 is never compared.
- Head X=250 (>=240), size=3 -> wallHit=1. Head Y=9'h1F6 (wrap from 0-10) -> wallHit=1.
- Pulse start again while busy at size=100 -> ignored, single done. Drop reset to 0 mid-SCAN -> all outputs 0 at once, no done. Next start runs normally.
- size=200 -> limit clamped to 128; done after E128. With the macro defined, a hit then a clean frame -> gameOver stays 1 until reset.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the snake collision checker and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_pkg;
    localparam int MAX_SEGS  = 128;
    localparam int X_W       = 8;
    localparam int Y_W       = 9;
    localparam int FIELD_W   = 240;
    localparam int FIELD_H   = 320;
    localparam int SEG_IDX_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/snake_seg_select.sv
// Extracts one segment's X/Y coordinate from the flattened snake-location vectors.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the producer holds the bus stable while it is being read.
module snake_seg_select
    import snake_pkg::*;
#(
    parameter int MAX_SEGS_P = MAX_SEGS,
    parameter int X_W_P      = X_W,
    parameter int Y_W_P      = Y_W,
    parameter int IDX_W_P    = SEG_IDX_W
) (
    input  logic [MAX_SEGS_P*X_W_P-1:0] loc_x,
    input  logic [MAX_SEGS_P*Y_W_P-1:0] loc_y,
    input  logic [IDX_W_P-1:0]          idx,
    output logic [X_W_P-1:0]            seg_x,
    output logic [Y_W_P-1:0]            seg_y
);
    logic [X_W_P-1:0] xs [MAX_SEGS_P];
    logic [Y_W_P-1:0] ys [MAX_SEGS_P];

    for (genvar g = 0; g < MAX_SEGS_P; g++) begin : g_unpack
        assign xs[g] = loc_x[g*X_W_P +: X_W_P];
        assign ys[g] = loc_y[g*Y_W_P +: Y_W_P];
    end

    // Index-driven mux over the unpacked slots.
    always_comb begin
        seg_x = xs[idx];
        seg_y = ys[idx];
    end
endmodule

// File: rtl/snake_collision_checker.sv
// Per-frame check of the snake head against its body (self hit) and the playfield bounds (wall hit).
// Latency: done pulses the cycle after edge j for a body hit at index j, otherwise after edge limit.
// Backpressure: none; start is only accepted in IDLE, ignored otherwise. Optional sticky loss flag: SNAKE_COLLIDE_STICKY_GAMEOVER_EN.
module snake_collision_checker
    import snake_pkg::*;
#(
    parameter int MAX_SEGS_P = MAX_SEGS,
    parameter int X_W_P      = X_W,
    parameter int Y_W_P      = Y_W,
    parameter int FIELD_W_P  = FIELD_W,
    parameter int FIELD_H_P  = FIELD_H
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MAX_SEGS_P*X_W_P-1:0]   snakeLocX,
    input  logic [MAX_SEGS_P*Y_W_P-1:0]   snakeLocY,
    input  logic [7:0]                    size,
    output logic                          busy,
    output logic                          done,
    output logic                          selfHit,
    output logic                          wallHit,
    output logic [SEG_IDX_W-1:0]          hitIndex,
    output logic                          gameOver
);
    // Counter is one bit wider than the index so it can reach a limit of MAX_SEGS.
    localparam int CNT_W = SEG_IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_SEGS_C = CNT_W'(MAX_SEGS_P);
    localparam logic [X_W_P:0]   FIELD_W_C  = (X_W_P+1)'(FIELD_W_P);
    localparam logic [Y_W_P:0]   FIELD_H_C  = (Y_W_P+1)'(FIELD_H_P);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     limit_q, limit_d;
    logic [X_W_P-1:0]     head_x_q, head_x_d;
    logic [Y_W_P-1:0]     head_y_q, head_y_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 self_hit_q, self_hit_d;
    logic                 wall_hit_q, wall_hit_d;
    logic [SEG_IDX_W-1:0] hit_index_q, hit_index_d;
    logic [X_W_P-1:0]     seg_x;
    logic [Y_W_P-1:0]     seg_y;
    logic [X_W_P-1:0]     bus_head_x;
    logic [Y_W_P-1:0]     bus_head_y;

    assign bus_head_x = snakeLocX[X_W_P-1:0];
    assign bus_head_y = snakeLocY[Y_W_P-1:0];

    // Index wraps to slot 0 when idx reaches MAX_SEGS, but the limit test fires first so that read is discarded.
    snake_seg_select #(
        .MAX_SEGS_P (MAX_SEGS_P),
        .X_W_P      (X_W_P),
        .Y_W_P      (Y_W_P),
        .IDX_W_P    (SEG_IDX_W)
    ) u_seg_select (
        .loc_x (snakeLocX),
        .loc_y (snakeLocY),
        .idx   (idx_q[SEG_IDX_W-1:0]),
        .seg_x (seg_x),
        .seg_y (seg_y)
    );

`ifdef SNAKE_COLLIDE_STICKY_GAMEOVER_EN
    logic game_over_q, game_over_d;
    // Loss flag latches on any flagged frame and is only cleared by reset.
    always_comb begin
        game_over_d = game_over_q | ((state_q == DONE) && (self_hit_q || wall_hit_q));
    end
    assign gameOver = game_over_q;
`else
    assign gameOver = 1'b0;
`endif

    // Next-state and output computation for the IDLE -> SCAN -> DONE walk.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        limit_d     = limit_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        self_hit_d  = self_hit_q;
        wall_hit_d  = wall_hit_q;
        hit_index_d = hit_index_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    head_x_d = bus_head_x;
                    head_y_d = bus_head_y;
                    if (size == 8'd0)
                        limit_d = CNT_W'(1);
                    else if (CNT_W'(size) > MAX_SEGS_C)
                        limit_d = MAX_SEGS_C;
                    else
                        limit_d = CNT_W'(size);
                    // Unsigned compare: a head that wrapped below zero lands far out and counts as a wall hit.
                    wall_hit_d  = ({1'b0, bus_head_x} >= FIELD_W_C) || ({1'b0, bus_head_y} >= FIELD_H_C);
                    self_hit_d  = 1'b0;
                    hit_index_d = '0;
                    idx_d       = CNT_W'(1);
                    busy_d      = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (idx_q >= limit_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if ((seg_x == head_x_q) && (seg_y == head_y_q)) begin
                    self_hit_d  = 1'b1;
                    hit_index_d = idx_q[SEG_IDX_W-1:0];
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any scan immediately without a done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            limit_q     <= '0;
            head_x_q    <= '0;
            head_y_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            self_hit_q  <= 1'b0;
            wall_hit_q  <= 1'b0;
            hit_index_q <= '0;
`ifdef SNAKE_COLLIDE_STICKY_GAMEOVER_EN
            game_over_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            limit_q     <= limit_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            self_hit_q  <= self_hit_d;
            wall_hit_q  <= wall_hit_d;
            hit_index_q <= hit_index_d;
`ifdef SNAKE_COLLIDE_STICKY_GAMEOVER_EN
            game_over_q <= game_over_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign selfHit  = self_hit_q;
    assign wallHit  = wall_hit_q;
    assign hitIndex = hit_index_q;
endmodule

// File: tb/tb_snake_collision_checker.sv
// Directed plus randomized bench for snake_collision_checker against a frame-level reference model.
// Latency: checks the done cycle count exactly for every frame.
// Backpressure: exercises ignored start pulses while busy and reset mid-scan.
module tb_snake_collision_checker;
    localparam int NS = 128;

    logic               clock;
    logic               reset;
    logic               start;
    logic [NS*8-1:0]    snakeLocX;
    logic [NS*9-1:0]    snakeLocY;
    logic [7:0]         size;
    logic               busy;
    logic               done;
    logic               selfHit;
    logic               wallHit;
    logic [6:0]         hitIndex;
    logic               gameOver;

    logic [7:0] xs [NS];
    logic [8:0] ys [NS];
    int         n_cmp;
    int         n_err;
    bit         go_exp;

    snake_collision_checker dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .snakeLocX (snakeLocX),
        .snakeLocY (snakeLocY),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .selfHit   (selfHit),
        .wallHit   (wallHit),
        .hitIndex  (hitIndex),
        .gameOver  (gameOver)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pack_bus();
        for (int i = 0; i < NS; i++) begin
            snakeLocX[i*8 +: 8] = xs[i];
            snakeLocY[i*9 +: 9] = ys[i];
        end
    endtask

    // Background segments all sit on row 0, away from the (100,160) head used by directed frames.
    task automatic fill_bg();
        for (int i = 0; i < NS; i++) begin
            xs[i] = 8'(i);
            ys[i] = 9'd0;
        end
        xs[0] = 8'd100;
        ys[0] = 9'd160;
    endtask

    // Frame-level reference: which body slot first equals the head, bounds test, and cycle count.
    task automatic model(input int sz, output int n, output bit sh, output bit wh, output int hi);
        int lim;
        lim = (sz == 0) ? 1 : ((sz > NS) ? NS : sz);
        wh  = (int'(xs[0]) >= 240) || (int'(ys[0]) >= 320);
        sh  = 1'b0;
        hi  = 0;
        n   = lim;
        for (int j = 1; j < lim; j++) begin
            if (xs[j] == xs[0] && ys[j] == ys[0]) begin
                sh = 1'b1;
                hi = j;
                n  = j;
                break;
            end
        end
    endtask

    // Runs one frame from a negedge; pulse_at > 0 raises start again mid-scan to prove it is ignored.
    task automatic run_frame(input string tag, input int sz, input int pulse_at);
        int n_exp, hi_exp, lat;
        bit sh_exp, wh_exp;
        model(sz, n_exp, sh_exp, wh_exp, hi_exp);
        pack_bus();
        size  = 8'(sz);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            start = (k == pulse_at);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(n_exp));
        check({tag, ".selfHit"}, 32'(selfHit), 32'(sh_exp));
        check({tag, ".wallHit"}, 32'(wallHit), 32'(wh_exp));
        check({tag, ".hitIndex"}, 32'(hitIndex), 32'(hi_exp));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clock);
`ifdef SNAKE_COLLIDE_STICKY_GAMEOVER_EN
        if (sh_exp || wh_exp) go_exp = 1'b1;
`endif
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".gameOver"}, 32'(gameOver), 32'(go_exp));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        go_exp    = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        size      = 8'd0;
        snakeLocX = '0;
        snakeLocY = '0;
        repeat (3) @(negedge clock);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.selfHit", 32'(selfHit), 32'd0);
        check("reset.wallHit", 32'(wallHit), 32'd0);
        check("reset.hitIndex", 32'(hitIndex), 32'd0);
        check("reset.gameOver", 32'(gameOver), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single-segment snake: done after E1.
        fill_bg();
        run_frame("size1", 1, 0);

        // Five segments, no overlap.
        fill_bg();
        xs[1] = 8'd90; ys[1] = 9'd160;
        xs[2] = 8'd80; ys[2] = 9'd160;
        xs[3] = 8'd80; ys[3] = 9'd170;
        xs[4] = 8'd90; ys[4] = 9'd170;
        run_frame("size5", 5, 0);

        // Hit at 4; slot 5 also matches but first match wins.
        fill_bg();
        xs[4] = 8'd100; ys[4] = 9'd160;
        xs[5] = 8'd100; ys[5] = 9'd160;
        run_frame("hit4", 6, 0);

        // Wall hits on X and on wrapped Y.
        fill_bg();
        xs[0] = 8'd250;
        run_frame("wallx", 3, 0);
        fill_bg();
        ys[0] = 9'h1F6;
        run_frame("wally", 3, 0);

        // Both flags in one frame.
        fill_bg();
        xs[0] = 8'd245; xs[2] = 8'd245; ys[2] = 9'd160;
        run_frame("both", 4, 0);

        // Start pulsed while busy is ignored; no second done afterwards.
        fill_bg();
        run_frame("busy_restart", 100, 10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("busy_restart.no_extra_done", 32'(done), 32'd0);
            check("busy_restart.idle", 32'(busy), 32'd0);
        end

        // Reset mid-scan clears everything at once with no done.
        fill_bg();
        xs[0] = 8'd250;
        pack_bus();
        size  = 8'd100;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        check("midreset.pre_busy", 32'(busy), 32'd1);
        check("midreset.pre_wall", 32'(wallHit), 32'd1);
        reset = 1'b0;
        #1;
        go_exp = 1'b0;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        check("midreset.wallHit", 32'(wallHit), 32'd0);
        check("midreset.selfHit", 32'(selfHit), 32'd0);
        check("midreset.hitIndex", 32'(hitIndex), 32'd0);
        check("midreset.gameOver", 32'(gameOver), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("midreset.no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        fill_bg();
        run_frame("post_reset", 7, 0);

        // Oversized count clamps to 128; zero count behaves like one.
        fill_bg();
        run_frame("clamp200", 200, 0);
        fill_bg();
        run_frame("size0", 0, 0);

        // Randomized frames: dense small grid for frequent hits, sparse grid for long scans.
        for (int f = 0; f < 60; f++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < NS; i++) begin
                if (mode == 0) begin
                    xs[i] = 8'($urandom_range(0, 3));
                    ys[i] = 9'($urandom_range(0, 3));
                end else begin
                    xs[i] = 8'($urandom_range(0, 255));
                    ys[i] = 9'($urandom_range(0, 511));
                end
            end
            if ($urandom_range(0, 3) == 0) xs[0] = 8'($urandom_range(240, 255));
            if ($urandom_range(0, 3) == 0) ys[0] = 9'($urandom_range(320, 511));
            run_frame("random", int'($urandom_range(0, 255)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
